// File: rtl/div_unit_pkg.sv
// Shared CPU defines for the divider: FSM encodings, start/ready levels and the zero word.
// The execute stage imports the same constants when it talks to div_unit.
package div_unit_pkg;

  localparam logic [1:0] DivFree   = 2'b00;
  localparam logic [1:0] DivByZero = 2'b01;
  localparam logic [1:0] DivOn     = 2'b10;
  localparam logic [1:0] DivEnd    = 2'b11;

  localparam logic DivStart = 1'b1;
  localparam logic DivStop  = 1'b0;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for the HI/LO path (DIV/DIVU).
// result_o = {remainder, quotient}; ready_o rises 33 edges after capture (1 edge for divide-by-zero).
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  logic [1:0]          r_state;
  logic [5:0]          r_cnt;
  logic [2*DATA_W:0]   r_dividend;
  logic [DATA_W-1:0]   r_divisor;
  logic                r_negQuo;
  logic                r_negRem;
  logic [2*DATA_W-1:0] r_result;
  logic                r_ready;

  logic                w_op1Neg;
  logic                w_op2Neg;
  logic [DATA_W-1:0]   w_absOp1;
  logic [DATA_W-1:0]   w_absOp2;
  logic [DATA_W:0]     w_trial;
  logic [DATA_W-1:0]   w_quo;
  logic [DATA_W-1:0]   w_rem;
  logic [DATA_W-1:0]   w_quoFix;
  logic [DATA_W-1:0]   w_remFix;

  assign w_op1Neg = signed_div_i & opdata1_i[DATA_W-1];
  assign w_op2Neg = signed_div_i & opdata2_i[DATA_W-1];
  assign w_absOp1 = w_op1Neg ? -opdata1_i : opdata1_i;
  assign w_absOp2 = w_op2Neg ? -opdata2_i : opdata2_i;

  // Trial subtract on the upper bits; a set borrow bit means the divisor did not fit.
  assign w_trial  = {1'b0, r_dividend[2*DATA_W-1:DATA_W]} - {1'b0, r_divisor};

  assign w_quo    = r_dividend[DATA_W-1:0];
  assign w_rem    = r_dividend[2*DATA_W:DATA_W+1];
  assign w_quoFix = r_negQuo ? -w_quo : w_quo;
  assign w_remFix = r_negRem ? -w_rem : w_rem;

  // Divisor and sign flags are latched at capture so operand changes mid-divide are harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= DivFree;
      r_cnt      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_negQuo   <= 1'b0;
      r_negRem   <= 1'b0;
      r_result   <= '0;
      r_ready    <= DivResultNotReady;
    end else begin
      case (r_state)
        DivFree: begin
          r_result <= '0;
          r_ready  <= DivResultNotReady;
          if (start_i == DivStart && !annul_i) begin
            r_divisor  <= w_absOp2;
            r_negQuo   <= w_op1Neg ^ w_op2Neg;
            r_negRem   <= w_op1Neg;
            r_cnt      <= '0;
            r_dividend <= {{DATA_W{1'b0}}, w_absOp1, 1'b0};
            r_state    <= (opdata2_i == '0) ? DivByZero : DivOn;
          end
        end
        DivByZero: begin
          if (annul_i) begin
            r_state <= DivFree;
          end else begin
            r_dividend <= {1'b0, ZeroWord, ZeroWord};
            r_result   <= {ZeroWord, ZeroWord};
            r_ready    <= DivResultReady;
            r_state    <= DivEnd;
          end
        end
        DivOn: begin
          if (annul_i) begin
            r_state <= DivFree;
          end else if (r_cnt != 6'd32) begin
            if (w_trial[DATA_W]) begin
              r_dividend <= {r_dividend[2*DATA_W-1:0], 1'b0};
            end else begin
              r_dividend <= {w_trial[DATA_W-1:0], r_dividend[DATA_W-1:0], 1'b1};
            end
            r_cnt <= r_cnt + 6'd1;
          end else begin
            r_result <= {w_remFix, w_quoFix};
            r_ready  <= DivResultReady;
            r_state  <= DivEnd;
          end
        end
        DivEnd: begin
          if (start_i == DivStop) begin
            r_result <= '0;
            r_ready  <= DivResultNotReady;
            r_state  <= DivFree;
          end
        end
        default: begin
          r_state <= DivFree;
        end
      endcase
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: expected results go into a scoreboard queue at start
// and are popped when ready_o rises; latency, hold, annul and async reset are checked too.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        signedDiv;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int assertCount = 0;
  int failCount   = 0;
  logic [63:0] scoreboard[$];

  div_unit #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signedDiv),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference divider built from the language's own signed/unsigned operators.
  function automatic logic [63:0] expModel(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'h0) return 64'h0;
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    assert (observed === expected)
      else begin
        failCount++;
        $error("[TB] FAIL %s: observed 0x%016h expected 0x%016h", tag, observed, expected);
      end
  endtask

  // Waits for ready_o after the capture edge, bounded; returns the edge count.
  task automatic waitReady(output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!ready && edges < 40);
  endtask

  task automatic applyStimulus(input string tag, input logic sgn, input logic [31:0] a,
                               input logic [31:0] b, input logic [63:0] exp, input int holdCycles);
    int edges;
    logic [63:0] want;
    @(negedge clk);
    signedDiv = sgn;
    op1       = a;
    op2       = b;
    start     = 1'b1;
    scoreboard.push_back(exp);
    @(posedge clk);
    #2;
    signedDiv = ~sgn;
    op1       = ~a;
    op2       = b ^ 32'h0000_0005;
    waitReady(edges);
    checkOutput({tag, "/latency"}, 64'(edges), (b == 32'h0) ? 64'd1 : 64'd33);
    want = scoreboard.pop_front();
    checkOutput({tag, "/result"}, result, want);
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge clk);
      #1;
      checkOutput({tag, "/holdResult"}, result, want);
      checkOutput({tag, "/holdReady"}, 64'(ready), 64'd1);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput({tag, "/dropReady"}, 64'(ready), 64'd0);
    checkOutput({tag, "/dropResult"}, result, 64'h0);
  endtask

  task automatic checkNoReady(input string tag, input int cycles);
    logic sawReady;
    sawReady = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (ready) sawReady = 1'b1;
    end
    checkOutput(tag, 64'(sawReady), 64'd0);
  endtask

  initial begin
    int edges;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] want;

    rst = 1'b1; signedDiv = 1'b0; op1 = '0; op2 = '0; start = 1'b0; annul = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset/ready", 64'(ready), 64'd0);
    checkOutput("reset/result", result, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus("u100div7", 1'b0, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 3);
    applyStimulus("sNeg7div2", 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1);
    applyStimulus("sMinDivNeg1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1);
    applyStimulus("uDivZero", 1'b0, 32'd5, 32'd0, 64'h0, 1);
    applyStimulus("sDivZero", 1'b1, 32'hFFFF_FFFB, 32'd0, 64'h0, 1);
    applyStimulus("uMaxDiv1", 1'b0, 32'hFFFF_FFFF, 32'd1, 64'h0000_0000_FFFF_FFFF, 1);
    applyStimulus("sNeg100div7", 1'b1, 32'hFFFF_FF9C, 32'd7, 64'hFFFF_FFFE_FFFF_FFF2, 0);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom >> (i * 8);
      if (rb == 32'h0) rb = 32'd3;
      applyStimulus("random", i[0], ra, rb, expModel(i[0], ra, rb), 0);
    end

    // Annul at step 10 of a running divide.
    @(negedge clk);
    signedDiv = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul = 1'b1; start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("annulOn/ready", 64'(ready), 64'd0);
    @(negedge clk);
    annul = 1'b0;
    checkNoReady("annulOn/neverReady", 40);
    applyStimulus("afterAnnul", 1'b0, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1);

    // Annul in divide-by-zero, then annul blocking a start in FREE.
    @(negedge clk);
    op2 = 32'd0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    annul = 1'b1; start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("annulByZero/ready", 64'(ready), 64'd0);
    @(negedge clk);
    op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    checkNoReady("annulFree/neverReady", 40);

    // Asynchronous reset at step 20.
    @(negedge clk);
    signedDiv = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("rstOn/ready", 64'(ready), 64'd0);
    checkOutput("rstOn/result", result, 64'h0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("afterRstOn", 1'b0, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 0);

    // Asynchronous reset while a result is being held.
    @(negedge clk);
    signedDiv = 1'b0; op1 = 32'hFFFF_FFFF; op2 = 32'd1; start = 1'b1;
    scoreboard.push_back(64'h0000_0000_FFFF_FFFF);
    @(posedge clk);
    waitReady(edges);
    want = scoreboard.pop_front();
    checkOutput("rstEnd/resultBefore", result, want);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rstEnd/ready", 64'(ready), 64'd0);
    checkOutput("rstEnd/result", result, 64'h0);
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    applyStimulus("afterRstEnd", 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1);

    checkOutput("scoreboardEmpty", 64'(scoreboard.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
